rename_regfile_ckpt: RTL and testbench

- Parametrised successor of the single-path rename register file.
- Maps architectural registers to a physical register file, allocates destinations from a free list and tracks in-flight renames in an active list.
- Adds in-order retirement by writeback tag, exact-width occupancy counters, and a multi-cycle flush/rollback state machine that restores the map table.
- Sits between decode (rename lookup) and writeback (result + completion).

---
 rtl/rename_regfile_ckpt.sv | 164 ++++++++++++++++
 tb/tb_rename_regfile_ckpt.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_regfile_ckpt.sv
// Rename register file with free list, active list, in-order retire
// and multi-cycle flush rollback. Optional: WB_BYPASS_EN (wb->read bypass).
module rename_regfile_ckpt #(
  parameter int DATA_WIDTH      = 32,
  parameter int ARCH_ADDR_WIDTH = 5,
  parameter int AL_WIDTH        = 3,
  parameter int PHYS_ADDR_WIDTH = ARCH_ADDR_WIDTH + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_in_i,
  input  logic [ARCH_ADDR_WIDTH-1:0] rs_addr_i,
  input  logic [ARCH_ADDR_WIDTH-1:0] rt_addr_i,
  output logic [DATA_WIDTH-1:0]      rs_data_o,
  output logic [DATA_WIDTH-1:0]      rt_data_o,
  output logic [PHYS_ADDR_WIDTH-1:0] phys_rs_o,
  output logic [PHYS_ADDR_WIDTH-1:0] phys_rt_o,
  input  logic                       rd_valid_i,
  input  logic [ARCH_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [PHYS_ADDR_WIDTH-1:0] phys_rd_o,
  output logic [AL_WIDTH-1:0]        alloc_tag_o,
  output logic                       stall_out_o,
  input  logic                       wb_en_i,
  input  logic [PHYS_ADDR_WIDTH-1:0] wb_phys_addr_i,
  input  logic [DATA_WIDTH-1:0]      wb_data_i,
  input  logic [AL_WIDTH-1:0]        wb_tag_i,
  input  logic                       flush_i,
  output logic                       rollback_busy_o,
  output logic [AL_WIDTH:0]          free_count_o
);

  localparam int NARCH = 1 << ARCH_ADDR_WIDTH;
  localparam int NAL   = 1 << AL_WIDTH;
  localparam int NPHYS = NARCH + NAL;

  typedef enum logic {S_RUN, S_ROLLBACK} state_e;

  state_e                     state_q;
  logic [PHYS_ADDR_WIDTH-1:0] map_q      [NARCH];
  logic [DATA_WIDTH-1:0]      preg_q     [NPHYS];
  logic [PHYS_ADDR_WIDTH-1:0] free_q     [NAL];
  logic [ARCH_ADDR_WIDTH-1:0] act_arch_q [NAL];
  logic [PHYS_ADDR_WIDTH-1:0] act_old_q  [NAL];
  logic [PHYS_ADDR_WIDTH-1:0] act_new_q  [NAL];
  logic [NAL-1:0]             act_done_q;
  logic [AL_WIDTH-1:0]        fhead_q, ftail_q;
  logic [AL_WIDTH-1:0]        ahead_q, atail_q;
  logic [AL_WIDTH:0]          free_cnt_q, free_cnt_d;
  logic [AL_WIDTH:0]          act_cnt_q, act_cnt_d;

  logic                       run;
  logic                       req;
  logic                       do_alloc;
  logic                       do_retire;
  logic                       do_pop;
  logic                       free_push;
  logic [AL_WIDTH-1:0]        atail_m1;
  logic [PHYS_ADDR_WIDTH-1:0] push_val;

  assign run       = (state_q == S_RUN);
  assign req       = rd_valid_i && (rd_addr_i != '0) && !stall_in_i;
  assign stall_out_o = req && ((free_cnt_q == '0) || !run || flush_i);
  assign do_alloc  = req && !stall_out_o;
  assign do_retire = run && !flush_i && (act_cnt_q != '0)
                     && act_done_q[ahead_q];
  // Rollback is only ever entered with live entries, so pop each cycle.
  assign do_pop    = !run;
  assign free_push = do_retire || do_pop;
  assign atail_m1  = atail_q - AL_WIDTH'(1);
  assign push_val  = do_pop ? act_new_q[atail_m1] : act_old_q[ahead_q];

  assign phys_rs_o = map_q[rs_addr_i];
  assign phys_rt_o = map_q[rt_addr_i];
  assign phys_rd_o = (rd_addr_i == '0) ? '0 : free_q[fhead_q];
  assign alloc_tag_o     = atail_q;
  assign rollback_busy_o = !run;
  assign free_count_o    = free_cnt_q;

  // Operand read, optionally forwarding a same-cycle writeback
  always_comb begin
    rs_data_o = (rs_addr_i == '0) ? '0 : preg_q[phys_rs_o];
    rt_data_o = (rt_addr_i == '0) ? '0 : preg_q[phys_rt_o];
`ifdef WB_BYPASS_EN
    if (wb_en_i && (wb_phys_addr_i != '0) && (rs_addr_i != '0)
        && (wb_phys_addr_i == phys_rs_o))
      rs_data_o = wb_data_i;
    if (wb_en_i && (wb_phys_addr_i != '0) && (rt_addr_i != '0)
        && (wb_phys_addr_i == phys_rt_o))
      rt_data_o = wb_data_i;
`endif
  end

  // Occupancy counters: alloc takes one, retire/rollback return one
  always_comb begin
    free_cnt_d = free_cnt_q;
    act_cnt_d  = act_cnt_q;
    if (free_push) free_cnt_d = free_cnt_d + 1'b1;
    if (do_alloc)  free_cnt_d = free_cnt_d - 1'b1;
    if (do_alloc)  act_cnt_d  = act_cnt_d + 1'b1;
    if (free_push) act_cnt_d  = act_cnt_d - 1'b1;
  end

  // Pointers, counters and the run/rollback state machine
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_RUN;
      fhead_q    <= '0;
      ftail_q    <= '0;
      ahead_q    <= '0;
      atail_q    <= '0;
      free_cnt_q <= (AL_WIDTH+1)'(NAL);
      act_cnt_q  <= '0;
    end else begin
      free_cnt_q <= free_cnt_d;
      act_cnt_q  <= act_cnt_d;
      if (do_alloc)  fhead_q <= fhead_q + 1'b1;
      if (free_push) ftail_q <= ftail_q + 1'b1;
      if (do_retire) ahead_q <= ahead_q + 1'b1;
      if (do_alloc)  atail_q <= atail_q + 1'b1;
      if (do_pop)    atail_q <= atail_m1;
      unique case (state_q)
        S_RUN:
          if (flush_i && (act_cnt_q != '0)) state_q <= S_ROLLBACK;
        S_ROLLBACK:
          if (act_cnt_q == (AL_WIDTH+1)'(1)) state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  // Map table, free list and active list storage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NARCH; i++)
        map_q[i] <= PHYS_ADDR_WIDTH'(i);
      for (int k = 0; k < NAL; k++)
        free_q[k] <= PHYS_ADDR_WIDTH'(NARCH + k);
      act_done_q <= '0;
    end else begin
      if (free_push) free_q[ftail_q] <= push_val;
      if (do_pop) map_q[act_arch_q[atail_m1]] <= act_old_q[atail_m1];
      if (wb_en_i && run) act_done_q[wb_tag_i] <= 1'b1;
      if (do_retire) act_done_q[ahead_q] <= 1'b0;
      if (do_alloc) begin
        map_q[rd_addr_i]     <= free_q[fhead_q];
        act_arch_q[atail_q]  <= rd_addr_i;
        act_old_q[atail_q]   <= map_q[rd_addr_i];
        act_new_q[atail_q]   <= free_q[fhead_q];
        act_done_q[atail_q]  <= 1'b0;
      end
    end
  end

  // Physical register file; p0 is never written
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NPHYS; i++)
        preg_q[i] <= '0;
    end else if (wb_en_i && (wb_phys_addr_i != '0)) begin
      preg_q[wb_phys_addr_i] <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_rename_regfile_ckpt.sv
// Bench for rename_regfile_ckpt: directed plan plus random traffic
// against a queue-based reference model.
module tb_rename_regfile_ckpt;

  localparam int NARCH = 32;
  localparam int NAL   = 8;
  localparam int NPHYS = 40;

  logic        clk = 1'b0;
  logic        rst, stall_in, rd_valid, wb_en, flush;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [5:0]  wb_phys;
  logic [31:0] wb_data;
  logic [2:0]  wb_tag;
  logic [31:0] rs_data, rt_data;
  logic [5:0]  phys_rs, phys_rt, phys_rd;
  logic [2:0]  alloc_tag;
  logic        stall_out, rollback_busy;
  logic [3:0]  free_count;

  always #5 clk = ~clk;

  rename_regfile_ckpt dut (
    .clk_i(clk), .rst_i(rst), .stall_in_i(stall_in),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rs_data_o(rs_data), .rt_data_o(rt_data),
    .phys_rs_o(phys_rs), .phys_rt_o(phys_rt),
    .rd_valid_i(rd_valid), .rd_addr_i(rd_addr),
    .phys_rd_o(phys_rd), .alloc_tag_o(alloc_tag),
    .stall_out_o(stall_out), .wb_en_i(wb_en),
    .wb_phys_addr_i(wb_phys), .wb_data_i(wb_data),
    .wb_tag_i(wb_tag), .flush_i(flush),
    .rollback_busy_o(rollback_busy), .free_count_o(free_count)
  );

  typedef struct {
    int arch;
    int oldp;
    int newp;
    bit done;
  } ent_t;

  int          m_map [NARCH];
  logic [31:0] m_preg[NPHYS];
  int          m_free[$];
  ent_t        m_act [$];
  int          m_head;
  bit          m_rb;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NARCH; i++) m_map[i] = i;
    for (int i = 0; i < NPHYS; i++) m_preg[i] = '0;
    m_free.delete();
    for (int k = 0; k < NAL; k++) m_free.push_back(NARCH + k);
    m_act.delete();
    m_head = 0;
    m_rb   = 1'b0;
  endtask

  function automatic logic [31:0] m_read(int a);
    int p;
    if (a == 0) return '0;
    p = m_map[a];
`ifdef WB_BYPASS_EN
    if (wb_en && wb_phys != 0 && int'(wb_phys) == p) return wb_data;
`endif
    return m_preg[p];
  endfunction

  function automatic bit m_req();
    return rd_valid && rd_addr != 0 && !stall_in;
  endfunction

  function automatic bit m_stall();
    return m_req() && (m_free.size() == 0 || m_rb || flush);
  endfunction

  task automatic model_check();
    if (rst) return;
    chk("phys_rs", phys_rs, m_map[rs_addr]);
    chk("phys_rt", phys_rt, m_map[rt_addr]);
    chk("rs_data", rs_data, m_read(int'(rs_addr)));
    chk("rt_data", rt_data, m_read(int'(rt_addr)));
    chk("stall_out", stall_out, m_stall());
    chk("free_count", free_count, m_free.size());
    chk("rollback_busy", rollback_busy, m_rb);
    chk("alloc_tag", alloc_tag, (m_head + m_act.size()) % NAL);
    if (rd_addr == 0) chk("phys_rd_zero", phys_rd, 0);
    else if (m_free.size() > 0) chk("phys_rd", phys_rd, m_free[0]);
  endtask

  task automatic drive(bit r, bit st, bit rv, int rd, int rs, int rt,
                       bit we, int wp, logic [31:0] wd, int wt, bit fl);
    rst      = r;
    stall_in = st;
    rd_valid = rv;
    rd_addr  = 5'(rd);
    rs_addr  = 5'(rs);
    rt_addr  = 5'(rt);
    wb_en    = we;
    wb_phys  = 6'(wp);
    wb_data  = wd;
    wb_tag   = 3'(wt);
    flush    = fl;
    #3;
    model_check();
  endtask

  task automatic idle(int rs = 0, int rt = 0);
    drive(0, 0, 0, 0, rs, rt, 0, 0, '0, 0, 0);
  endtask

  task automatic tick();
    bit   alloc, retire;
    int   idx;
    ent_t e;
    if (rst) begin
      m_reset();
    end else begin
      alloc  = m_req() && !m_stall();
      retire = !m_rb && !flush && m_act.size() > 0 && m_act[0].done;
      if (wb_en && wb_phys != 0) m_preg[wb_phys] = wb_data;
      if (wb_en && !m_rb) begin
        idx = (int'(wb_tag) - m_head + NAL) % NAL;
        if (idx < m_act.size()) m_act[idx].done = 1'b1;
      end
      if (m_rb) begin
        e = m_act.pop_back();
        m_map[e.arch] = e.oldp;
        m_free.push_back(e.newp);
        if (m_act.size() == 0) m_rb = 1'b0;
      end else begin
        if (retire) begin
          e = m_act.pop_front();
          m_free.push_back(e.oldp);
          m_head = (m_head + 1) % NAL;
        end
        if (alloc) begin
          e.arch = rd_addr;
          e.oldp = m_map[rd_addr];
          e.newp = m_free.pop_front();
          e.done = 1'b0;
          m_map[rd_addr] = e.newp;
          m_act.push_back(e);
        end
        if (flush && m_act.size() > 0) m_rb = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
    tick();
    tick();
  endtask

  initial begin
    int   rd, wp, wt, k;
    bit   we;
    do_reset();

    // reset defaults
    idle(7, 0);
    chk("t1_phys_rs", phys_rs, 7);
    chk("t1_rs_data", rs_data, 0);
    chk("t1_free", free_count, 8);
    chk("t1_stall", stall_out, 0);
    chk("t1_busy", rollback_busy, 0);
    tick();

    // alloc, writeback, retire
    drive(0, 0, 1, 3, 0, 0, 0, 0, '0, 0, 0);
    chk("t2_phys_rd", phys_rd, 32);
    chk("t2_tag", alloc_tag, 0);
    tick();
    idle(3, 0);
    chk("t2_map", phys_rs, 32);
    tick();
    drive(0, 0, 0, 0, 3, 0, 1, 32, 32'hDEAD, 0, 0);
    tick();
    idle(3, 0);
    chk("t2_rs_data", rs_data, 32'hDEAD);
    tick();
    idle();
    chk("t2_free_back", free_count, 8);
    tick();

    // fill the free list, stall, then recover via retire
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 3 + i, 0, 0, 0, 0, '0, 0, 0);
      chk("t3_phys_rd", phys_rd, 32 + i);
      tick();
    end
    drive(0, 0, 1, 20, 3, 0, 0, 0, '0, 0, 0);
    chk("t3_stall", stall_out, 1);
    chk("t3_empty", free_count, 0);
    tick();
    idle(3, 20);
    chk("t3_map_kept", phys_rs, 32);
    chk("t3_map20", phys_rt, 20);
    drive(0, 0, 0, 0, 0, 0, 1, 32, 32'h5, 0, 0);
    tick();
    idle();
    tick();
    drive(0, 0, 1, 21, 0, 0, 0, 0, '0, 0, 0);
    chk("t3_reuse", phys_rd, 3);
    chk("t3_nostall", stall_out, 0);
    tick();

    // flush and rollback
    do_reset();
    drive(0, 0, 1, 1, 0, 0, 0, 0, '0, 0, 0);
    chk("t4_a0", phys_rd, 32);
    tick();
    drive(0, 0, 1, 2, 0, 0, 0, 0, '0, 0, 0);
    chk("t4_a1", phys_rd, 33);
    tick();
    drive(0, 0, 1, 1, 0, 0, 0, 0, '0, 0, 0);
    chk("t4_a2", phys_rd, 34);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, '0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t4_busy", rollback_busy, 1);
      tick();
    end
    idle(1, 2);
    chk("t4_idle", rollback_busy, 0);
    chk("t4_r1", phys_rs, 1);
    chk("t4_r2", phys_rt, 2);
    chk("t4_free", free_count, 8);
    drive(0, 0, 1, 5, 0, 0, 0, 0, '0, 0, 0);
    chk("t4_next", phys_rd, 35);
    tick();

    // r0 destination and p0 writeback
    drive(0, 0, 1, 0, 0, 0, 0, 0, '0, 0, 0);
    chk("t5_rd0", phys_rd, 0);
    chk("t5_free", free_count, 7);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h55, 5, 0);
    tick();
    idle();
    chk("t5_r0", rs_data, 0);
    chk("t5_free2", free_count, 7);
    tick();

    // same-cycle writeback visibility
    do_reset();
    drive(0, 0, 1, 4, 0, 0, 0, 0, '0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 4, 0, 1, 32, 32'h1234, 0, 0);
`ifdef WB_BYPASS_EN
    chk("t6_bypass", rs_data, 32'h1234);
`else
    chk("t6_nobypass", rs_data, 0);
`endif
    tick();
    idle(4, 0);
    chk("t6_after", rs_data, 32'h1234);
    tick();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      we = ($urandom_range(0, 1) == 1);
      if (m_act.size() > 0 && $urandom_range(0, 3) != 0) begin
        k  = $urandom_range(0, m_act.size() - 1);
        wp = m_act[k].newp;
        wt = (m_head + k) % NAL;
      end else begin
        wp = $urandom_range(1, NPHYS - 1);
        wt = $urandom_range(0, NAL - 1);
      end
      rd = $urandom_range(0, NARCH - 1);
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1, rd,
            $urandom_range(0, NARCH - 1),
            $urandom_range(0, NARCH - 1),
            we, wp, $urandom, wt,
            $urandom_range(0, 24) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
